// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, branch/jump resolution, iterative MUL (result C+1 cycles after accept).
// ex_stall_out holds ID/EX while the multiplier iterates or mem_stall_in is high; flush_in and rst override both.
module execute_stage_mc #(
   parameter int DATA_WIDTH     = 32,
   parameter int PC_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MUL_STEP_BITS  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_in,
   input  logic [3:0]                alu_op_in,
   input  logic [DATA_WIDTH-1:0]     data_a_in,
   input  logic [DATA_WIDTH-1:0]     data_b_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_a_addr_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_b_addr_in,
   input  logic [DATA_WIDTH-1:0]     constant_in,
   input  logic                      imm_inst_in,
   input  logic                      reg_wr_en_in,
   input  logic                      mem_rd_en_in,
   input  logic                      mem_wr_en_in,
   input  logic                      wb_sel_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
   input  logic [PC_WIDTH-1:0]       pc_in,
   input  logic                      branch_inst_in,
   input  logic                      branch_ne_in,
   input  logic                      jmp_inst_in,
   input  logic                      jmp_use_r_in,
   input  logic [DATA_WIDTH-1:0]     mem_wb_data_in,
   input  logic [REG_ADDR_WIDTH-1:0] mem_wb_reg_addr_in,
   input  logic                      mem_wb_reg_wr_en_in,
   input  logic                      mem_stall_in,
   input  logic                      flush_in,
   output logic                      ex_stall_out,
   output logic                      valid_out,
   output logic                      reg_wr_en_out,
   output logic                      mem_rd_en_out,
   output logic                      mem_wr_en_out,
   output logic                      wb_sel_out,
   output logic                      select_new_pc_out,
   output logic [DATA_WIDTH-1:0]     alu_data_out,
   output logic [DATA_WIDTH-1:0]     mem_data_out,
   output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
   output logic [PC_WIDTH-1:0]       new_pc_out
);

   localparam int C   = DATA_WIDTH / MUL_STEP_BITS;
   localparam int CW  = (C > 1) ? $clog2(C) : 1;
   localparam int SHW = $clog2(DATA_WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_SEQ  = 4'd10;
   localparam logic [3:0] OP_SNE  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_mul_a;
   logic [DATA_WIDTH-1:0] r_mul_b;
   logic [DATA_WIDTH-1:0] r_acc;

   logic                  w_exm_a, w_exm_b, w_mwb_a, w_mwb_b;
   logic [DATA_WIDTH-1:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu_res;
   logic [DATA_WIDTH-1:0] w_digit, w_mul_sum;
   logic [SHW-1:0]        w_shamt;
   logic                  w_mul_start, w_mul_last, w_busy_stall;
   logic                  w_taken, w_sel_pc;
   logic [PC_WIDTH-1:0]   w_new_pc;

   // EX/MEM wins over MEM/WB; load results (wb_sel) are not yet available in EX/MEM
   assign w_exm_a = valid_out & reg_wr_en_out & ~wb_sel_out &
                    (reg_a_addr_in == reg_wr_addr_out) & (reg_a_addr_in != '0);
   assign w_exm_b = valid_out & reg_wr_en_out & ~wb_sel_out &
                    (reg_b_addr_in == reg_wr_addr_out) & (reg_b_addr_in != '0);
   assign w_mwb_a = mem_wb_reg_wr_en_in & (reg_a_addr_in == mem_wb_reg_addr_in) & (reg_a_addr_in != '0);
   assign w_mwb_b = mem_wb_reg_wr_en_in & (reg_b_addr_in == mem_wb_reg_addr_in) & (reg_b_addr_in != '0);

   assign w_fwd_a = w_exm_a ? alu_data_out : (w_mwb_a ? mem_wb_data_in : data_a_in);
   assign w_fwd_b = w_exm_b ? alu_data_out : (w_mwb_b ? mem_wb_data_in : data_b_in);
   assign w_alu_b = imm_inst_in ? constant_in : w_fwd_b;
   assign w_shamt = w_alu_b[SHW-1:0];

   always_comb begin
      w_alu_res = '0;
      case (alu_op_in)
         OP_ADD:  w_alu_res = w_fwd_a + w_alu_b;
         OP_SUB:  w_alu_res = w_fwd_a - w_alu_b;
         OP_AND:  w_alu_res = w_fwd_a & w_alu_b;
         OP_OR:   w_alu_res = w_fwd_a | w_alu_b;
         OP_XOR:  w_alu_res = w_fwd_a ^ w_alu_b;
         OP_SLL:  w_alu_res = w_fwd_a << w_shamt;
         OP_SRL:  w_alu_res = w_fwd_a >> w_shamt;
         OP_SRA:  w_alu_res = $signed(w_fwd_a) >>> w_shamt;
         OP_SLT:  w_alu_res = DATA_WIDTH'($signed(w_fwd_a) < $signed(w_alu_b));
         OP_SLTU: w_alu_res = DATA_WIDTH'(w_fwd_a < w_alu_b);
         OP_SEQ:  w_alu_res = DATA_WIDTH'(w_fwd_a == w_alu_b);
         OP_SNE:  w_alu_res = DATA_WIDTH'(w_fwd_a != w_alu_b);
         default: w_alu_res = '0;
      endcase
   end

   assign w_taken  = (w_fwd_a == '0) ^ branch_ne_in;
   assign w_sel_pc = valid_in & (jmp_inst_in | (branch_inst_in & w_taken));
   assign w_new_pc = (jmp_inst_in & jmp_use_r_in) ? w_fwd_a[PC_WIDTH-1:0]
                                                  : pc_in + PC_WIDTH'($signed(constant_in));

   // Radix-2^MUL_STEP_BITS shift-add; the final partial sum feeds the pipe register directly
   assign w_digit   = DATA_WIDTH'(r_mul_b[MUL_STEP_BITS-1:0]);
   assign w_mul_sum = r_acc + r_mul_a * w_digit;

   assign w_mul_start  = (r_state == S_IDLE) & valid_in & (alu_op_in == OP_MUL) & ~flush_in;
   assign w_mul_last   = (r_state == S_BUSY) & (r_cnt == CW'(C - 1));
   assign w_busy_stall = w_mul_start | ((r_state == S_BUSY) & ~w_mul_last);
   assign ex_stall_out = w_busy_stall | mem_stall_in;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_mul_start) w_state_nxt = S_BUSY;
         S_BUSY:  if (w_mul_last && !mem_stall_in) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush_in) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mul_a <= '0;
         r_mul_b <= '0;
      end else if (flush_in) begin
         r_cnt <= '0;
      end else if (w_mul_start) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mul_a <= w_fwd_a;
         r_mul_b <= w_alu_b;
      end else if ((r_state == S_BUSY) && !w_mul_last) begin
         r_cnt   <= r_cnt + CW'(1);
         r_acc   <= w_mul_sum;
         r_mul_a <= r_mul_a << MUL_STEP_BITS;
         r_mul_b <= r_mul_b >> MUL_STEP_BITS;
      end else if (w_mul_last && !mem_stall_in) begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out         <= 1'b0;
         reg_wr_en_out     <= 1'b0;
         mem_rd_en_out     <= 1'b0;
         mem_wr_en_out     <= 1'b0;
         wb_sel_out        <= 1'b0;
         select_new_pc_out <= 1'b0;
         alu_data_out      <= '0;
         mem_data_out      <= '0;
         reg_wr_addr_out   <= '0;
         new_pc_out        <= '0;
      end else if (flush_in) begin
         valid_out         <= 1'b0;
         reg_wr_en_out     <= 1'b0;
         mem_rd_en_out     <= 1'b0;
         mem_wr_en_out     <= 1'b0;
         wb_sel_out        <= 1'b0;
         select_new_pc_out <= 1'b0;
      end else if (!mem_stall_in) begin
         if (w_busy_stall) begin
            // Bubble while the multiplier iterates so downstream never sees a duplicate
            valid_out         <= 1'b0;
            reg_wr_en_out     <= 1'b0;
            mem_rd_en_out     <= 1'b0;
            mem_wr_en_out     <= 1'b0;
            wb_sel_out        <= 1'b0;
            select_new_pc_out <= 1'b0;
         end else begin
            valid_out         <= valid_in;
            reg_wr_en_out     <= valid_in & reg_wr_en_in;
            mem_rd_en_out     <= valid_in & mem_rd_en_in;
            mem_wr_en_out     <= valid_in & mem_wr_en_in;
            wb_sel_out        <= valid_in & wb_sel_in;
            select_new_pc_out <= w_sel_pc;
            alu_data_out      <= w_mul_last ? w_mul_sum : w_alu_res;
            mem_data_out      <= w_fwd_b;
            reg_wr_addr_out   <= reg_wr_addr_in;
            new_pc_out        <= w_new_pc;
         end
      end
   end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Bench for execute_stage_mc: directed scenarios plus a randomized instruction stream checked
// against an architectural register model.
module tb_execute_stage_mc;
   localparam int C = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [3:0]  alu_op_in;
   logic [31:0] data_a_in, data_b_in, constant_in, mem_wb_data_in;
   logic [4:0]  reg_a_addr_in, reg_b_addr_in, reg_wr_addr_in, mem_wb_reg_addr_in;
   logic        imm_inst_in, reg_wr_en_in, mem_rd_en_in, mem_wr_en_in, wb_sel_in;
   logic [31:0] pc_in;
   logic        branch_inst_in, branch_ne_in, jmp_inst_in, jmp_use_r_in;
   logic        mem_wb_reg_wr_en_in, mem_stall_in, flush_in;
   logic        ex_stall_out, valid_out, reg_wr_en_out, mem_rd_en_out, mem_wr_en_out;
   logic        wb_sel_out, select_new_pc_out;
   logic [31:0] alu_data_out, mem_data_out, new_pc_out;
   logic [4:0]  reg_wr_addr_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   execute_stage_mc dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .alu_op_in(alu_op_in),
      .data_a_in(data_a_in), .data_b_in(data_b_in),
      .reg_a_addr_in(reg_a_addr_in), .reg_b_addr_in(reg_b_addr_in),
      .constant_in(constant_in), .imm_inst_in(imm_inst_in),
      .reg_wr_en_in(reg_wr_en_in), .mem_rd_en_in(mem_rd_en_in),
      .mem_wr_en_in(mem_wr_en_in), .wb_sel_in(wb_sel_in),
      .reg_wr_addr_in(reg_wr_addr_in), .pc_in(pc_in),
      .branch_inst_in(branch_inst_in), .branch_ne_in(branch_ne_in),
      .jmp_inst_in(jmp_inst_in), .jmp_use_r_in(jmp_use_r_in),
      .mem_wb_data_in(mem_wb_data_in), .mem_wb_reg_addr_in(mem_wb_reg_addr_in),
      .mem_wb_reg_wr_en_in(mem_wb_reg_wr_en_in), .mem_stall_in(mem_stall_in),
      .flush_in(flush_in), .ex_stall_out(ex_stall_out), .valid_out(valid_out),
      .reg_wr_en_out(reg_wr_en_out), .mem_rd_en_out(mem_rd_en_out),
      .mem_wr_en_out(mem_wr_en_out), .wb_sel_out(wb_sel_out),
      .select_new_pc_out(select_new_pc_out), .alu_data_out(alu_data_out),
      .mem_data_out(mem_data_out), .reg_wr_addr_out(reg_wr_addr_out),
      .new_pc_out(new_pc_out)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      int          s;
      logic [31:0] r;
      s = int'(b[4:0]);
      case (op)
         0:  return a + b;
         1:  return a - b;
         2:  return a & b;
         3:  return a | b;
         4:  return a ^ b;
         5:  return a << s;
         6:  return a >> s;
         7: begin
            r = a >> s;
            if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
            return r;
         end
         8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         9:  return (a < b) ? 32'd1 : 32'd0;
         10: return (a == b) ? 32'd1 : 32'd0;
         11: return (a != b) ? 32'd1 : 32'd0;
         12: return a * b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      valid_in = 0; alu_op_in = 0; data_a_in = 0; data_b_in = 0;
      reg_a_addr_in = 0; reg_b_addr_in = 0; constant_in = 0; imm_inst_in = 0;
      reg_wr_en_in = 0; mem_rd_en_in = 0; mem_wr_en_in = 0; wb_sel_in = 0;
      reg_wr_addr_in = 0; pc_in = 0; branch_inst_in = 0; branch_ne_in = 0;
      jmp_inst_in = 0; jmp_use_r_in = 0; mem_wb_data_in = 0; mem_wb_reg_addr_in = 0;
      mem_wb_reg_wr_en_in = 0; mem_stall_in = 0; flush_in = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1; valid_in = 1; data_a_in = 5; data_b_in = 7; reg_wr_en_in = 1;
      flush_in = 1; mem_stall_in = 1;
      tick(); tick();
      n_checks++;
      if ({valid_out, reg_wr_en_out, mem_rd_en_out, mem_wr_en_out, wb_sel_out, select_new_pc_out} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b%b%b%b%b%b expected 000000", valid_out, reg_wr_en_out,
                  mem_rd_en_out, mem_wr_en_out, wb_sel_out, select_new_pc_out);
      end
      n_checks++;
      if ({alu_data_out, mem_data_out, reg_wr_addr_out, new_pc_out} !== 101'b0) begin
         n_fail++;
         $display("FAIL reset_data: alu %h mem %h addr %h pc %h expected all 0",
                  alu_data_out, mem_data_out, reg_wr_addr_out, new_pc_out);
      end
      clear_inputs();
      rst = 0;
      @(negedge clk);
      n_checks++;
      if (ex_stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", ex_stall_out); end
      tick();
   endtask

   task automatic test_add();
      clear_inputs();
      valid_in = 1; alu_op_in = 0; data_a_in = 5; data_b_in = 7;
      reg_a_addr_in = 4; reg_b_addr_in = 5; reg_wr_en_in = 1; reg_wr_addr_in = 9;
      @(negedge clk);
      n_checks++;
      if (ex_stall_out !== 1'b0) begin n_fail++; $display("FAIL add_stall: got %b expected 0", ex_stall_out); end
      tick();
      n_checks++;
      if (alu_data_out !== 32'd12 || valid_out !== 1'b1) begin
         n_fail++;
         $display("FAIL add_result: got %h valid %b expected 0000000c valid 1", alu_data_out, valid_out);
      end
      clear_inputs(); tick();
   endtask

   task automatic test_forward();
      clear_inputs();
      valid_in = 1; alu_op_in = 0; data_a_in = 5; data_b_in = 7;
      reg_a_addr_in = 4; reg_b_addr_in = 5; reg_wr_en_in = 1; reg_wr_addr_in = 1;
      tick();
      alu_op_in = 1; reg_a_addr_in = 1; data_a_in = 32'hDEAD; reg_b_addr_in = 3; data_b_in = 2;
      reg_wr_addr_in = 2;
      @(negedge clk);
      n_checks++;
      if (ex_stall_out !== 1'b0) begin n_fail++; $display("FAIL fwd_stall: got %b expected 0", ex_stall_out); end
      tick();
      n_checks++;
      if (alu_data_out !== 32'd10) begin n_fail++; $display("FAIL fwd_exmem: got %h expected 0000000a", alu_data_out); end
      // r1 now arrives through MEM/WB, r2 through EX/MEM
      alu_op_in = 4; reg_a_addr_in = 1; data_a_in = 32'h1111; reg_b_addr_in = 2; data_b_in = 32'h2222;
      reg_wr_addr_in = 6;
      mem_wb_reg_wr_en_in = 1; mem_wb_reg_addr_in = 1; mem_wb_data_in = 12;
      tick();
      n_checks++;
      if (alu_data_out !== 32'd6) begin n_fail++; $display("FAIL fwd_memwb: got %h expected 00000006", alu_data_out); end
      clear_inputs(); tick(); tick();
   endtask

   task automatic test_random_program();
      logic [31:0] m_true [4];
      logic [31:0] m_rf [4];
      logic [31:0] h_res [64];
      logic [1:0]  h_rd [64];
      logic        h_we [64];
      int          op;
      logic [1:0]  rs1, rs2, rd;
      logic        v, we, imm, mw;
      logic [31:0] cst, ta, tb, bv, exp;
      clear_inputs(); tick(); tick();
      for (int r = 0; r < 4; r++) begin
         m_true[r] = (r == 0) ? 32'd0 : $urandom;
         m_rf[r]   = m_true[r];
      end
      for (int i = 0; i < 60; i++) begin
         if (i >= 3 && h_we[i-3] && h_rd[i-3] != 2'd0) m_rf[h_rd[i-3]] = h_res[i-3];
         if (i >= 2) begin
            mem_wb_reg_wr_en_in = h_we[i-2];
            mem_wb_reg_addr_in  = 5'(h_rd[i-2]);
            mem_wb_data_in      = h_res[i-2];
         end else begin
            mem_wb_reg_wr_en_in = 0;
         end
         op = $urandom_range(0, 14);
         if (op >= 12) op++;
         rs1 = 2'($urandom); rs2 = 2'($urandom); rd = 2'($urandom);
         v   = ($urandom_range(0, 7) != 0);
         we  = 1'($urandom); imm = 1'($urandom); mw = 1'($urandom); cst = $urandom;
         ta  = m_true[rs1]; tb = m_true[rs2];
         bv  = imm ? cst : tb;
         exp = ref_alu(op, ta, bv);
         valid_in = v; alu_op_in = 4'(op);
         data_a_in = m_rf[rs1]; data_b_in = m_rf[rs2];
         reg_a_addr_in = 5'(rs1); reg_b_addr_in = 5'(rs2); reg_wr_addr_in = 5'(rd);
         reg_wr_en_in = we; imm_inst_in = imm; constant_in = cst; mem_wr_en_in = mw;
         @(negedge clk);
         n_checks++;
         if (ex_stall_out !== 1'b0) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b expected 0", i, ex_stall_out); end
         tick();
         n_checks++;
         if (valid_out !== v) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, valid_out, v); end
         if (v) begin
            n_checks++;
            if (alu_data_out !== exp) begin
               n_fail++;
               $display("FAIL rnd_alu[%0d] op %0d: got %h expected %h", i, op, alu_data_out, exp);
            end
            n_checks++;
            if (mem_data_out !== tb) begin n_fail++; $display("FAIL rnd_memdata[%0d]: got %h expected %h", i, mem_data_out, tb); end
            n_checks++;
            if ({reg_wr_en_out, reg_wr_addr_out, mem_wr_en_out} !== {we, 5'(rd), mw}) begin
               n_fail++;
               $display("FAIL rnd_ctrl[%0d]: got %b/%0d/%b expected %b/%0d/%b", i, reg_wr_en_out,
                        reg_wr_addr_out, mem_wr_en_out, we, rd, mw);
            end
         end else begin
            n_checks++;
            if ({reg_wr_en_out, mem_wr_en_out} !== 2'b00) begin
               n_fail++;
               $display("FAIL rnd_bubble[%0d]: got %b%b expected 00", i, reg_wr_en_out, mem_wr_en_out);
            end
         end
         h_we[i] = v & we; h_rd[i] = rd; h_res[i] = exp;
         if (v && we && rd != 2'd0) m_true[rd] = exp;
      end
      clear_inputs(); tick(); tick();
   endtask

   task automatic test_mul_back_to_back();
      logic [31:0] a, b, p;
      int          lat, stalls;
      for (int j = 0; j < 4; j++) begin
         a = (j == 0) ? 32'hFFFF_FFFF : $urandom;
         b = (j == 0) ? 32'd3 : $urandom;
         p = ref_alu(12, a, b);
         clear_inputs();
         valid_in = 1; alu_op_in = 12; data_a_in = a; data_b_in = b;
         reg_a_addr_in = 20; reg_b_addr_in = 21; reg_wr_en_in = 1; reg_wr_addr_in = 5'(j + 1);
         lat = 0; stalls = 0;
         while (lat < 40) begin
            @(negedge clk);
            if (ex_stall_out) stalls++;
            tick();
            lat++;
            if (lat == 1) begin data_a_in = $urandom; data_b_in = $urandom; end
            if (valid_out) break;
         end
         n_checks++;
         if (lat !== C + 1) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", j, lat, C + 1); end
         n_checks++;
         if (stalls !== C) begin n_fail++; $display("FAIL mul_stalls[%0d]: got %0d expected %0d", j, stalls, C); end
         n_checks++;
         if (alu_data_out !== p || reg_wr_addr_out !== 5'(j + 1)) begin
            n_fail++;
            $display("FAIL mul_result[%0d]: got %h rd %0d expected %h rd %0d", j, alu_data_out, reg_wr_addr_out, p, j + 1);
         end
         // Dependent ADD right behind the multiply takes the product from EX/MEM
         alu_op_in = 0; reg_a_addr_in = 5'(j + 1); data_a_in = 0; reg_b_addr_in = 21; data_b_in = 1;
         reg_wr_addr_in = 10;
         @(negedge clk);
         n_checks++;
         if (ex_stall_out !== 1'b0) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %b expected 0", j, ex_stall_out); end
         tick();
         n_checks++;
         if (alu_data_out !== p + 32'd1) begin
            n_fail++;
            $display("FAIL b2b_add[%0d]: got %h expected %h", j, alu_data_out, p + 32'd1);
         end
      end
      clear_inputs(); tick();
   endtask

   task automatic test_branch();
      logic        v, br, ne, jmp, ur, sel;
      logic [31:0] a, pc, cst, tgt;
      for (int k = 0; k < 14; k++) begin
         if (k == 0) begin v = 1; br = 1; ne = 1; jmp = 0; ur = 0; a = 0; end
         else if (k == 1) begin v = 1; br = 0; ne = 0; jmp = 1; ur = 1; a = 32'h100; end
         else begin
            v = ($urandom_range(0, 5) != 0); br = 1'($urandom); ne = 1'($urandom);
            jmp = 1'($urandom); ur = 1'($urandom);
            a = $urandom_range(0, 1) ? 32'd0 : $urandom;
         end
         pc = $urandom; cst = $urandom;
         sel = v & (jmp | (br & ((a == 0) != ne)));
         tgt = (jmp & ur) ? a : pc + cst;
         clear_inputs();
         valid_in = v; alu_op_in = 0; data_a_in = a; data_b_in = $urandom;
         reg_wr_en_in = 1; reg_wr_addr_in = 0; pc_in = pc; constant_in = cst;
         branch_inst_in = br; branch_ne_in = ne; jmp_inst_in = jmp; jmp_use_r_in = ur;
         tick();
         n_checks++;
         if (select_new_pc_out !== sel) begin
            n_fail++;
            $display("FAIL branch_sel[%0d]: got %b expected %b", k, select_new_pc_out, sel);
         end
         if (sel) begin
            n_checks++;
            if (new_pc_out !== tgt) begin n_fail++; $display("FAIL branch_pc[%0d]: got %h expected %h", k, new_pc_out, tgt); end
         end
      end
      clear_inputs(); tick();
   endtask

   task automatic test_flush();
      clear_inputs();
      valid_in = 1; alu_op_in = 0; data_a_in = 1; data_b_in = 2; reg_wr_en_in = 1; reg_wr_addr_in = 3;
      flush_in = 1;
      tick();
      n_checks++;
      if ({valid_out, reg_wr_en_out} !== 2'b00) begin
         n_fail++; $display("FAIL flush_kill: got %b%b expected 00", valid_out, reg_wr_en_out);
      end
      flush_in = 0;
      tick();
      n_checks++;
      if (valid_out !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %b expected 1", valid_out); end
      valid_in = 0; mem_stall_in = 1; flush_in = 1;
      tick();
      n_checks++;
      if ({valid_out, reg_wr_en_out} !== 2'b00) begin
         n_fail++; $display("FAIL flush_over_stall: got %b%b expected 00", valid_out, reg_wr_en_out);
      end
      clear_inputs();
      valid_in = 1; alu_op_in = 12; data_a_in = 9; data_b_in = 9; reg_wr_en_in = 1; reg_wr_addr_in = 4;
      repeat (4) tick();
      flush_in = 1;
      tick();
      clear_inputs();
      n_checks++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_busy_valid: got %b expected 0", valid_out); end
      @(negedge clk);
      n_checks++;
      if (ex_stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_busy_stall: got %b expected 0", ex_stall_out); end
      tick();
      valid_in = 1; alu_op_in = 0; data_a_in = 1; data_b_in = 2; reg_wr_addr_in = 5;
      @(negedge clk);
      n_checks++;
      if (ex_stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b expected 0", ex_stall_out); end
      tick();
      n_checks++;
      if (alu_data_out !== 32'd3 || valid_out !== 1'b1) begin
         n_fail++; $display("FAIL flush_after_add: got %h valid %b expected 00000003 valid 1", alu_data_out, valid_out);
      end
      clear_inputs(); tick();
   endtask

   task automatic test_mem_stall();
      clear_inputs();
      valid_in = 1; alu_op_in = 0; data_a_in = 100; data_b_in = 23; reg_wr_en_in = 1; reg_wr_addr_in = 7;
      tick();
      alu_op_in = 1; data_a_in = 50; data_b_in = 8; mem_stall_in = 1;
      @(negedge clk);
      n_checks++;
      if (ex_stall_out !== 1'b1) begin n_fail++; $display("FAIL mstall_stall: got %b expected 1", ex_stall_out); end
      repeat (3) tick();
      n_checks++;
      if (alu_data_out !== 32'd123 || valid_out !== 1'b1) begin
         n_fail++; $display("FAIL mstall_hold: got %h valid %b expected 0000007b valid 1", alu_data_out, valid_out);
      end
      mem_stall_in = 0;
      tick();
      n_checks++;
      if (alu_data_out !== 32'd42) begin n_fail++; $display("FAIL mstall_release: got %h expected 0000002a", alu_data_out); end
      clear_inputs();
      valid_in = 1; alu_op_in = 12; data_a_in = 6; data_b_in = 7; reg_wr_en_in = 1; reg_wr_addr_in = 8;
      repeat (C) tick();
      mem_stall_in = 1;
      @(negedge clk);
      n_checks++;
      if (ex_stall_out !== 1'b1) begin n_fail++; $display("FAIL mstall_mul_stall: got %b expected 1", ex_stall_out); end
      repeat (2) tick();
      n_checks++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mstall_mul_hold: got %b expected 0", valid_out); end
      mem_stall_in = 0;
      tick();
      n_checks++;
      if (alu_data_out !== 32'd42 || valid_out !== 1'b1) begin
         n_fail++; $display("FAIL mstall_mul_result: got %h valid %b expected 0000002a valid 1", alu_data_out, valid_out);
      end
      clear_inputs(); tick();
   endtask

   task automatic test_rst_mid_mul();
      clear_inputs();
      valid_in = 1; alu_op_in = 0; data_a_in = 32'h55; data_b_in = 32'h22; reg_wr_en_in = 1;
      reg_wr_addr_in = 9; jmp_inst_in = 1; pc_in = 32'h40; constant_in = 4;
      tick();
      n_checks++;
      if (select_new_pc_out !== 1'b1 || new_pc_out !== 32'h44) begin
         n_fail++; $display("FAIL rst_pre_jmp: got %b %h expected 1 00000044", select_new_pc_out, new_pc_out);
      end
      clear_inputs();
      valid_in = 1; alu_op_in = 12; data_a_in = 3; data_b_in = 5; reg_wr_en_in = 1; reg_wr_addr_in = 2;
      repeat (3) tick();
      rst = 1; flush_in = 1; mem_stall_in = 1;
      tick();
      n_checks++;
      if ({valid_out, reg_wr_en_out, mem_rd_en_out, mem_wr_en_out, wb_sel_out, select_new_pc_out,
           alu_data_out, mem_data_out, reg_wr_addr_out, new_pc_out} !== 107'b0) begin
         n_fail++;
         $display("FAIL rst_mid_mul: valid %b alu %h mem %h addr %h pc %h expected all 0",
                  valid_out, alu_data_out, mem_data_out, reg_wr_addr_out, new_pc_out);
      end
      rst = 0;
      clear_inputs();
      @(negedge clk);
      n_checks++;
      if (ex_stall_out !== 1'b0) begin n_fail++; $display("FAIL rst_idle_stall: got %b expected 0", ex_stall_out); end
      tick();
      n_checks++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_after_valid: got %b expected 0", valid_out); end
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      test_reset();
      test_add();
      test_forward();
      test_random_program();
      test_mul_back_to_back();
      test_branch();
      test_flush();
      test_mem_stall();
      test_rst_mid_mul();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/execute_stage_mc.md
EXECUTE_STAGE_MC -- requirements
Module: execute_stage_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter PC_WIDTH, default 32, program-counter width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, register-address width.
REQ-004 SHALL have parameter MUL_STEP_BITS, default 4, multiplier bits retired per cycle; DATA_WIDTH divisible by it; C = DATA_WIDTH/MUL_STEP_BITS.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  ID/EX holds a valid instruction
- alu_op_in  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 SEQ, 11 SNE, 12 MUL (low half, unsigned); 13-15 give 0
- data_a_in, data_b_in  in  DATA_WIDTH  register-file operands
- reg_a_addr_in, reg_b_addr_in  in  REG_ADDR_WIDTH  operand source addresses
- constant_in  in  DATA_WIDTH  sign-extended immediate
- imm_inst_in  in  1  ALU B = constant_in
- reg_wr_en_in, mem_rd_en_in, mem_wr_en_in, wb_sel_in  in  1  control to forward
- reg_wr_addr_in  in  REG_ADDR_WIDTH  destination
- pc_in  in  PC_WIDTH  PC of next instruction
- branch_inst_in, branch_ne_in, jmp_inst_in, jmp_use_r_in  in  1  control flow
- mem_wb_data_in  in  DATA_WIDTH; mem_wb_reg_addr_in  in  REG_ADDR_WIDTH; mem_wb_reg_wr_en_in  in  1  MEM/WB forwarding source
- mem_stall_in  in  1  downstream cannot accept
- flush_in  in  1  kill in-flight instruction
- ex_stall_out  out  1  upstream must hold ID/EX
- valid_out, reg_wr_en_out, mem_rd_en_out, mem_wr_en_out, wb_sel_out, select_new_pc_out  out  1  registered
- alu_data_out, mem_data_out  out  DATA_WIDTH; reg_wr_addr_out  out  REG_ADDR_WIDTH; new_pc_out  out  PC_WIDTH  registered

Function
REQ-007 Forwarding SHALL select per operand: EX/MEM (alu_data_out) if valid_out & reg_wr_en_out & !wb_sel_out & addr match; else MEM/WB if mem_wb_reg_wr_en_in & addr match; else register data; address 0 never forwarded.
REQ-008 ALU B SHALL be constant_in when imm_inst_in, else forwarded B; mem_data_out SHALL capture forwarded B.
REQ-009 Shifts SHALL use B[log2(DATA_WIDTH)-1:0]; SLT/SEQ/SNE/SLTU results SHALL be 0 or 1; ADD/SUB wrap modulo 2^DATA_WIDTH.
REQ-010 Non-MUL op accepted cycle N SHALL appear on outputs cycle N+1 with ex_stall_out low unless mem_stall_in.
REQ-011 Sequencer states: IDLE, BUSY; IDLE->BUSY on valid_in & op MUL & !flush_in, latching forwarded operands; BUSY retires MUL_STEP_BITS per cycle with counter 0..C-1; BUSY->IDLE after step C-1 and pipe load.
REQ-012 MUL accepted cycle N SHALL hold ex_stall_out high cycles N..N+C-1 and present result cycle N+C+1; operands SHALL not be re-sampled during BUSY.
REQ-013 Branch taken SHALL be (A==0) xor branch_ne_in; jump target SHALL be A[PC_WIDTH-1:0] when jmp_use_r_in else pc_in+constant_in; branch target pc_in+constant_in; select_new_pc_out = valid & (jmp_inst_in | taken branch).
REQ-014 ex_stall_out SHALL equal busy-stall | mem_stall_in; while mem_stall_in, pipe register and sequencer (at final step) SHALL hold.
REQ-015 flush_in SHALL, next edge, clear valid_out and all 1-bit control outputs, return sequencer to IDLE; flush_in SHALL win over mem_stall_in and busy.
REQ-016 Invalid cycles (valid_in low) SHALL load zeros into control outputs; data outputs don't-care.

Reset
REQ-017 rst SHALL set sequencer IDLE, counter 0, all outputs 0 at the next edge, including mid-multiply; rst SHALL win over flush_in and mem_stall_in.

Verification
REQ-018 ADD A=5, B=7 -> alu_data_out=12, valid_out=1 next cycle, stall never high.
REQ-019 Back-to-back ADD r1 then SUB r2=r1-r3 with r3=2 -> EX/MEM forward, 10 result, no stall.
REQ-020 MUL 0xFFFF_FFFF*3 (defaults, C=8) -> stall 8 cycles, result 0xFFFF_FFFD at cycle N+9.
REQ-021 BNEZ A=0 -> select_new_pc_out=0; JR A=0x100 -> select_new_pc_out=1, new_pc_out=0x100.
REQ-022 flush_in at BUSY cycle 3 -> IDLE, valid_out=0, stall low next cycle; rst mid-MUL -> all outputs 0.
